// File: rtl/ibex_branch_resolve.sv
// rtl/ibex_branch_resolve.sv - static branch prediction resolution and redirect
// Optional perf counters enabled by defining IBEX_BRANCH_RESOLVE_PERF_EN.
module ibex_branch_resolve #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pred_valid_i,
  output logic        pred_ready_o,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_pc_i,
  input  logic [31:0] pred_target_i,
  input  logic        res_valid_i,
  input  logic [31:0] res_pc_i,
  input  logic        res_taken_i,
  input  logic [31:0] res_target_i,
  input  logic        res_compressed_i,
  input  logic        flush_i,
`ifdef IBEX_BRANCH_RESOLVE_PERF_EN
  output logic [31:0] perf_branches_o,
  output logic [31:0] perf_mispredicts_o,
`endif
  output logic        mispredict_o,
  output logic [31:0] redirect_pc_o,
  output logic        seq_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [31:0]   r_pc    [DEPTH];
  logic [31:0]   r_tgt   [DEPTH];
  logic          r_taken [DEPTH];
  logic [AW:0]   r_rd_ptr;
  logic [AW:0]   r_wr_ptr;
  logic          r_mispredict;
  logic [31:0]   r_redirect;
  logic          r_seq_err;

  logic [AW-1:0] w_rd_idx;
  logic [AW-1:0] w_wr_idx;
  logic          w_empty;
  logic          w_full;
  logic          w_mispredict;
  logic          w_pc_err;
  logic          w_pop;
  logic          w_push;
  logic          w_kill;
  logic [31:0]   w_redirect;

  assign w_rd_idx = r_rd_ptr[AW-1:0];
  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_empty  = (r_rd_ptr == r_wr_ptr);
  assign w_full   = (r_rd_ptr[AW] != r_wr_ptr[AW]) && (w_rd_idx == w_wr_idx);

  // An empty queue means IF predicted fall-through for this instruction.
  always_comb begin
    w_mispredict = 1'b0;
    w_pc_err     = 1'b0;
    w_pop        = 1'b0;
    if (res_valid_i) begin
      if (w_empty) begin
        w_mispredict = res_taken_i;
      end else if (r_pc[w_rd_idx] != res_pc_i) begin
        w_pc_err     = 1'b1;
        w_mispredict = 1'b1;
      end else if (r_taken[w_rd_idx] != res_taken_i) begin
        w_mispredict = 1'b1;
      end else if (res_taken_i && (r_tgt[w_rd_idx] != res_target_i)) begin
        w_mispredict = 1'b1;
      end else begin
        w_pop = 1'b1;
      end
    end
  end

  // A correct pop frees the slot, so a push alongside it is taken even when full.
  assign w_kill     = w_mispredict & ~flush_i;
  assign w_push     = pred_valid_i & (~w_full | w_pop) & ~w_mispredict & ~flush_i;
  assign w_redirect = res_taken_i ? res_target_i
                                  : res_pc_i + (res_compressed_i ? 32'd2 : 32'd4);

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_pc[w_wr_idx]    <= pred_pc_i;
      r_tgt[w_wr_idx]   <= pred_target_i;
      r_taken[w_wr_idx] <= pred_taken_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_mispredict <= 1'b0;
      r_redirect   <= 32'd0;
      r_seq_err    <= 1'b0;
    end else begin
      r_mispredict <= w_kill;
      if (w_kill) begin
        r_redirect <= w_redirect;
      end
      if (w_pc_err && !flush_i) begin
        r_seq_err <= 1'b1;
      end
      if (flush_i || w_mispredict) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end
      end
    end
  end

  assign pred_ready_o  = ~w_full;
  assign mispredict_o  = r_mispredict;
  assign redirect_pc_o = r_redirect;
  assign seq_err_o     = r_seq_err;

`ifdef IBEX_BRANCH_RESOLVE_PERF_EN
  logic [31:0] r_perf_branches;
  logic [31:0] r_perf_mispredicts;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perf_branches    <= 32'd0;
      r_perf_mispredicts <= 32'd0;
    end else begin
      if (res_valid_i && !flush_i && (r_perf_branches != 32'hFFFF_FFFF)) begin
        r_perf_branches <= r_perf_branches + 32'd1;
      end
      if (w_kill && (r_perf_mispredicts != 32'hFFFF_FFFF)) begin
        r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
      end
    end
  end

  assign perf_branches_o    = r_perf_branches;
  assign perf_mispredicts_o = r_perf_mispredicts;
`endif

endmodule

// File: tb/tb_ibex_branch_resolve.sv
// tb/tb_ibex_branch_resolve.sv - directed self-checking bench for ibex_branch_resolve
module tb_ibex_branch_resolve;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        pred_valid_i = 1'b0;
  logic        pred_ready_o;
  logic        pred_taken_i = 1'b0;
  logic [31:0] pred_pc_i = 32'd0;
  logic [31:0] pred_target_i = 32'd0;
  logic        res_valid_i = 1'b0;
  logic [31:0] res_pc_i = 32'd0;
  logic        res_taken_i = 1'b0;
  logic [31:0] res_target_i = 32'd0;
  logic        res_compressed_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic        seq_err_o;
`ifdef IBEX_BRANCH_RESOLVE_PERF_EN
  logic [31:0] perf_branches_o;
  logic [31:0] perf_mispredicts_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  ibex_branch_resolve #(.DEPTH(4)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .pred_valid_i     (pred_valid_i),
    .pred_ready_o     (pred_ready_o),
    .pred_taken_i     (pred_taken_i),
    .pred_pc_i        (pred_pc_i),
    .pred_target_i    (pred_target_i),
    .res_valid_i      (res_valid_i),
    .res_pc_i         (res_pc_i),
    .res_taken_i      (res_taken_i),
    .res_target_i     (res_target_i),
    .res_compressed_i (res_compressed_i),
    .flush_i          (flush_i),
`ifdef IBEX_BRANCH_RESOLVE_PERF_EN
    .perf_branches_o    (perf_branches_o),
    .perf_mispredicts_o (perf_mispredicts_o),
`endif
    .mispredict_o     (mispredict_o),
    .redirect_pc_o    (redirect_pc_o),
    .seq_err_o        (seq_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    pred_valid_i  = 1'b1;
    pred_pc_i     = pc;
    pred_taken_i  = taken;
    pred_target_i = tgt;
  endtask

  task automatic set_res(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                         input logic comp);
    res_valid_i      = 1'b1;
    res_pc_i         = pc;
    res_taken_i      = taken;
    res_target_i     = tgt;
    res_compressed_i = comp;
  endtask

  task automatic idle();
    pred_valid_i     = 1'b0;
    res_valid_i      = 1'b0;
    flush_i          = 1'b0;
    res_compressed_i = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    set_push(pc, taken, tgt);
    cyc();
    idle();
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                         input logic comp);
    set_res(pc, taken, tgt, comp);
    cyc();
    idle();
  endtask

  initial begin
    cyc();
    cyc();
    chk("rst_ready", {31'd0, pred_ready_o}, 32'd1);
    chk("rst_mis", {31'd0, mispredict_o}, 32'd0);
    chk("rst_seq", {31'd0, seq_err_o}, 32'd0);
    chk("rst_redir", redirect_pc_o, 32'd0);
    rst_i = 1'b0;
    cyc();

    // correct taken prediction pops head
    push(32'h100, 1'b1, 32'h80);
    resolve(32'h100, 1'b1, 32'h80, 1'b0);
    chk("ok_mis", {31'd0, mispredict_o}, 32'd0);
    resolve(32'h104, 1'b0, 32'h0, 1'b0);
    chk("ok_empty_mis", {31'd0, mispredict_o}, 32'd0);
    chk("ok_empty_seq", {31'd0, seq_err_o}, 32'd0);

    // predicted not-taken, actually taken
    push(32'h200, 1'b0, 32'h0);
    resolve(32'h200, 1'b1, 32'h240, 1'b0);
    chk("dir_mis", {31'd0, mispredict_o}, 32'd1);
    chk("dir_redir", redirect_pc_o, 32'h240);
    cyc();
    chk("dir_pulse", {31'd0, mispredict_o}, 32'd0);
    chk("dir_hold", redirect_pc_o, 32'h240);

    // predicted taken, actually not-taken compressed; younger entry flushed
    push(32'h300, 1'b1, 32'h2F0);
    push(32'h304, 1'b0, 32'h0);
    resolve(32'h300, 1'b0, 32'h0, 1'b1);
    chk("nt_mis", {31'd0, mispredict_o}, 32'd1);
    chk("nt_redir", redirect_pc_o, 32'h302);
    resolve(32'h500, 1'b0, 32'h0, 1'b0);
    chk("nt_empty_mis", {31'd0, mispredict_o}, 32'd0);
    chk("nt_empty_seq", {31'd0, seq_err_o}, 32'd0);

    // fill to DEPTH, overflow push dropped, pop+push while full
    push(32'h10, 1'b0, 32'h0);
    push(32'h14, 1'b0, 32'h0);
    push(32'h18, 1'b0, 32'h0);
    chk("fill3_ready", {31'd0, pred_ready_o}, 32'd1);
    push(32'h1C, 1'b0, 32'h0);
    chk("full_ready", {31'd0, pred_ready_o}, 32'd0);
    push(32'h99C, 1'b1, 32'hAA0);
    chk("drop_ready", {31'd0, pred_ready_o}, 32'd0);
    set_push(32'h20, 1'b0, 32'h0);
    set_res(32'h10, 1'b0, 32'h0, 1'b0);
    cyc();
    idle();
    chk("pp_mis", {31'd0, mispredict_o}, 32'd0);
    chk("pp_ready", {31'd0, pred_ready_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      resolve(32'h14 + 32'(4 * i), 1'b0, 32'h0, 1'b0);
      chk($sformatf("drain%0d_mis", i), {31'd0, mispredict_o}, 32'd0);
    end
    chk("drain_ready", {31'd0, pred_ready_o}, 32'd1);
    chk("drain_seq", {31'd0, seq_err_o}, 32'd0);
    resolve(32'h99C, 1'b1, 32'hAA0, 1'b0);
    chk("drop_mis", {31'd0, mispredict_o}, 32'd1);
    chk("drop_redir", redirect_pc_o, 32'hAA0);

    // target mismatch with both taken
    push(32'h700, 1'b1, 32'h800);
    resolve(32'h700, 1'b1, 32'h804, 1'b0);
    chk("tgt_mis", {31'd0, mispredict_o}, 32'd1);
    chk("tgt_redir", redirect_pc_o, 32'h804);

    // 32-bit wrap of fall-through PC
    push(32'hFFFF_FFFC, 1'b1, 32'h1000);
    resolve(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
    chk("wrap_mis", {31'd0, mispredict_o}, 32'd1);
    chk("wrap_redir", redirect_pc_o, 32'h0);

    // sequence error is sticky
    push(32'h500, 1'b0, 32'h0);
    resolve(32'h400, 1'b0, 32'h0, 1'b0);
    chk("seq_mis", {31'd0, mispredict_o}, 32'd1);
    chk("seq_err", {31'd0, seq_err_o}, 32'd1);
    chk("seq_redir", redirect_pc_o, 32'h404);
    cyc();
    chk("seq_sticky", {31'd0, seq_err_o}, 32'd1);
    chk("seq_pulse", {31'd0, mispredict_o}, 32'd0);

    // flush with simultaneous mispredicting resolve
    push(32'h600, 1'b1, 32'h700);
    flush_i = 1'b1;
    set_res(32'h600, 1'b0, 32'h0, 1'b0);
    cyc();
    idle();
    chk("fl_mis", {31'd0, mispredict_o}, 32'd0);
    chk("fl_redir", redirect_pc_o, 32'h404);
    chk("fl_seq", {31'd0, seq_err_o}, 32'd1);
    resolve(32'h604, 1'b0, 32'h0, 1'b0);
    chk("fl_empty_mis", {31'd0, mispredict_o}, 32'd0);

    // asynchronous reset mid-operation
    push(32'h900, 1'b0, 32'h0);
    push(32'h904, 1'b0, 32'h0);
    push(32'h908, 1'b0, 32'h0);
    push(32'h90C, 1'b0, 32'h0);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_ready", {31'd0, pred_ready_o}, 32'd1);
    chk("arst_seq", {31'd0, seq_err_o}, 32'd0);
    chk("arst_redir", redirect_pc_o, 32'd0);
    cyc();
    rst_i = 1'b0;
    resolve(32'hA00, 1'b0, 32'h0, 1'b0);
    chk("arst_empty_mis", {31'd0, mispredict_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
